// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: producer request, RAM write port,
// cross-domain pointers and status flags.
interface fifo_wr_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              wr_en;
    logic [ADDR_W:0]   rd_gray_async;
    logic              mem_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_gray;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              overflow;

    modport master (
        output wr_en, rd_gray_async,
        input  mem_we, wr_addr, wr_gray, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  wr_en, rd_gray_async,
        output mem_we, wr_addr, wr_gray, full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO: pointers, read-pointer
// synchroniser, full/almost_full/level and sticky overflow.
package conversionFunctions;
    parameter int WIDTH = 9;

    function automatic logic [WIDTH:0] bin2gray(input logic [WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
        logic [WIDTH:0] b;
        b[WIDTH] = g[WIDTH];
        for (int i = WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
endpackage

module fifo_wr_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int AF_THRESH = 480
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_ctrl_if.slave      bus
);
    import conversionFunctions::*;

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wr_bin, wr_bin_nxt;
    logic [PW-1:0] wr_gray_q, gray_nxt;
    logic [PW-1:0] rd_sync1, rd_sync2;
    logic [PW-1:0] rd_bin, full_gray;
    logic [PW-1:0] level_q, level_nxt;
    logic          full_q, af_q, ovf_q;
    logic          accept;

    assign accept     = bus.wr_en & ~full_q & ~rst;
    assign wr_bin_nxt = accept ? wr_bin + 1'b1 : wr_bin;
    assign gray_nxt   = bin2gray(wr_bin_nxt);
    assign rd_bin     = gray2bin(rd_sync2);
    assign level_nxt  = wr_bin_nxt - rd_bin;
    // Write pointer exactly one lap ahead of the read pointer: top two Gray bits inverted.
    assign full_gray  = {~rd_sync2[PW-1:PW-2], rd_sync2[PW-3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bin    <= '0;
            wr_gray_q <= '0;
            rd_sync1  <= '0;
            rd_sync2  <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rd_sync1  <= bus.rd_gray_async;
            rd_sync2  <= rd_sync1;
            wr_bin    <= wr_bin_nxt;
            wr_gray_q <= gray_nxt;
            full_q    <= (gray_nxt == full_gray);
            level_q   <= level_nxt;
            af_q      <= (level_nxt >= PW'(AF_THRESH));
            ovf_q     <= ovf_q | (bus.wr_en & full_q);
        end
    end

    assign bus.mem_we      = accept;
    assign bus.wr_addr     = wr_bin[ADDR_W-1:0];
    assign bus.wr_gray     = wr_gray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wr_level    = level_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus randomized wrap traffic,
// checked against an occupancy-count model of the FIFO write side.
module tb_fifo_wr_ctrl;
    localparam int ADDR_W = 9;
    localparam int AF     = 480;
    localparam int DEPTH  = 512;
    localparam int PMOD   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fifo_wr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_wr_ctrl #(.ADDR_W(ADDR_W), .AF_THRESH(AF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // model: pointers as plain counts, synchroniser as two delayed copies
    int m_wr, m_s1, m_s2, m_level, n_acc;
    bit m_full, m_af, m_ovf, last_acc;
    bit exp_we, obs_we;
    int exp_addr, obs_addr;
    logic [9:0] prev_gray;

    function automatic logic [9:0] gray_of(input int b);
        logic [9:0] v;
        v = b[9:0];
        return v ^ (v >> 1);
    endfunction

    task automatic step(input bit we, input int rdp, input bit r);
        int wr_n;
        @(negedge clk);
        bus.wr_en         = we;
        bus.rd_gray_async = gray_of(rdp);
        rst               = r;
        #1;
        exp_we    = we && !m_full && !r;
        exp_addr  = m_wr % DEPTH;
        obs_we    = bus.mem_we;
        obs_addr  = int'(bus.wr_addr);
        prev_gray = bus.wr_gray;
        @(posedge clk);
        if (r) begin
            m_wr = 0; m_s1 = 0; m_s2 = 0; m_level = 0; n_acc = 0;
            m_full = 0; m_af = 0; m_ovf = 0; last_acc = 0;
        end else begin
            last_acc = we && !m_full;
            m_ovf    = m_ovf || (we && m_full);
            wr_n     = (m_wr + (last_acc ? 1 : 0)) % PMOD;
            m_level  = (wr_n - m_s2 + PMOD) % PMOD;
            m_full   = (m_level == DEPTH);
            m_af     = (m_level >= AF);
            m_s2     = m_s1;
            m_s1     = rdp % PMOD;
            m_wr     = wr_n;
            if (last_acc) n_acc++;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 1);
        n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %0b want 0", obs_we); end
        step(1, 0, 1);
        n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b want 0", bus.full); end
        n_cmp++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_af got %0b want 0", bus.almost_full); end
        n_cmp++; if (bus.wr_level !== 10'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", bus.wr_level); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %0b want 0", bus.overflow); end
        n_cmp++; if (bus.wr_gray !== 10'h000) begin n_fail++; $display("FAIL rst_gray got %h want 000", bus.wr_gray); end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            n_cmp++; if (bus.wr_gray !== 10'h000) begin n_fail++; $display("FAIL idle_gray cyc %0d got %h want 000", i, bus.wr_gray); end
        end
    endtask

    task automatic test_fill();
        int pulses = 0;
        for (int i = 0; i < 513; i++) begin
            step(1, 0, 0);
            if (obs_we) pulses++;
            n_cmp++; if (obs_we !== exp_we) begin n_fail++; $display("FAIL fill_we cyc %0d got %0b want %0b", i, obs_we, exp_we); end
            if (exp_we) begin
                n_cmp++; if (obs_addr != exp_addr) begin n_fail++; $display("FAIL fill_addr cyc %0d got %0d want %0d", i, obs_addr, exp_addr); end
            end
            n_cmp++; if (bus.full !== m_full) begin n_fail++; $display("FAIL fill_full cyc %0d got %0b want %0b", i, bus.full, m_full); end
            n_cmp++; if (bus.wr_level !== 10'(m_level)) begin n_fail++; $display("FAIL fill_level cyc %0d got %0d want %0d", i, bus.wr_level, m_level); end
            if (i == 511) begin
                n_cmp++; if (bus.wr_gray !== 10'h300) begin n_fail++; $display("FAIL fill_gray512 got %h want 300", bus.wr_gray); end
                n_cmp++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full512 got %0b want 1", bus.full); end
            end
        end
        n_cmp++; if (pulses != DEPTH) begin n_fail++; $display("FAIL fill_pulses got %0d want 512", pulses); end
        n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL fill_513_we got %0b want 0", obs_we); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %0b want 1", bus.overflow); end
        n_cmp++; if (bus.wr_level !== 10'd512) begin n_fail++; $display("FAIL fill_level_end got %0d want 512", bus.wr_level); end
        n_cmp++; if (bus.wr_gray !== 10'h300) begin n_fail++; $display("FAIL fill_gray_hold got %h want 300", bus.wr_gray); end
    endtask

    task automatic test_release();
        bit want_full [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            n_cmp++; if (bus.full !== want_full[i]) begin n_fail++; $display("FAIL rel_full edge %0d got %0b want %0b", i + 1, bus.full, want_full[i]); end
            n_cmp++; if (bus.full !== m_full) begin n_fail++; $display("FAIL rel_full_model edge %0d got %0b want %0b", i + 1, bus.full, m_full); end
        end
        n_cmp++; if (bus.wr_level !== 10'd511) begin n_fail++; $display("FAIL rel_level got %0d want 511", bus.wr_level); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL rel_ovf got %0b want 1", bus.overflow); end
    endtask

    task automatic test_almost_full();
        step(0, 0, 1);
        step(0, 0, 0);
        for (int i = 1; i <= 480; i++) begin
            step(1, 0, 0);
            n_cmp++; if (bus.almost_full !== m_af) begin n_fail++; $display("FAIL af cyc %0d got %0b want %0b", i, bus.almost_full, m_af); end
            if (i == 479) begin
                n_cmp++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL af_479 got %0b want 0", bus.almost_full); end
            end
        end
        n_cmp++; if (bus.almost_full !== 1'b1) begin n_fail++; $display("FAIL af_480 got %0b want 1", bus.almost_full); end
        n_cmp++; if (bus.wr_level !== 10'd480) begin n_fail++; $display("FAIL af_level got %0d want 480", bus.wr_level); end
        n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL af_full got %0b want 0", bus.full); end
    endtask

    task automatic test_wrap();
        int rd_total = 0;
        int iter = 0;
        bit saw_wrap = 0;
        int avail, adv;
        bit we;
        step(0, 0, 1);
        while (n_acc < 1100 && iter < 6000) begin
            iter++;
            we    = ($urandom % 4) != 0;
            avail = n_acc - rd_total;
            adv   = (avail > 0) ? int'($urandom_range(0, (avail > 3) ? 3 : avail)) : 0;
            rd_total += adv;
            step(we, rd_total, 0);
            if (prev_gray == 10'h200 && bus.wr_gray == 10'h000) saw_wrap = 1;
            n_cmp++; if (obs_we !== exp_we) begin n_fail++; $display("FAIL wrap_we it %0d got %0b want %0b", iter, obs_we, exp_we); end
            n_cmp++; if ($countones(prev_gray ^ bus.wr_gray) != (last_acc ? 1 : 0)) begin n_fail++; $display("FAIL wrap_gray_step it %0d got %h->%h want %0d bit change", iter, prev_gray, bus.wr_gray, last_acc ? 1 : 0); end
            n_cmp++; if (bus.wr_gray !== gray_of(m_wr)) begin n_fail++; $display("FAIL wrap_gray it %0d got %h want %h", iter, bus.wr_gray, gray_of(m_wr)); end
            n_cmp++; if (bus.wr_level !== 10'(m_level)) begin n_fail++; $display("FAIL wrap_level it %0d got %0d want %0d", iter, bus.wr_level, m_level); end
            n_cmp++; if (bus.full !== m_full) begin n_fail++; $display("FAIL wrap_full it %0d got %0b want %0b", iter, bus.full, m_full); end
            n_cmp++; if (bus.almost_full !== m_af) begin n_fail++; $display("FAIL wrap_af it %0d got %0b want %0b", iter, bus.almost_full, m_af); end
        end
        n_cmp++; if (n_acc < 1100) begin n_fail++; $display("FAIL wrap_budget got %0d writes want 1100", n_acc); end
        n_cmp++; if (!saw_wrap) begin n_fail++; $display("FAIL wrap_seen got 0 want 1"); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 0, 0);
        n_cmp++; if (bus.wr_level !== 10'd300) begin n_fail++; $display("FAIL mid_level_pre got %0d want 300", bus.wr_level); end
        step(1, 0, 1);
        n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL mid_we got %0b want 0", obs_we); end
        n_cmp++; if (bus.wr_gray !== 10'h000) begin n_fail++; $display("FAIL mid_gray got %h want 000", bus.wr_gray); end
        n_cmp++; if (bus.wr_level !== 10'd0) begin n_fail++; $display("FAIL mid_level got %0d want 0", bus.wr_level); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %0b want 0", bus.overflow); end
        step(1, 0, 0);
        n_cmp++; if (bus.wr_gray !== 10'h001) begin n_fail++; $display("FAIL mid_restart_gray got %h want 001", bus.wr_gray); end
    endtask

    initial begin
        bus.wr_en         = 1'b0;
        bus.rd_gray_async = '0;
        test_reset();
        test_fill();
        test_release();
        test_almost_full();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-side controller for the dual-clock FIFO. Runs entirely in the write clock domain.
- Owns the binary and Gray write pointers, and synchronises the read-domain Gray pointer through two flops.
- Produces full, almost_full, fill level and a sticky overflow flag.
- Gray encode/decode uses the conversionFunctions package (bin2gray, gray2bin). Pointer width is ADDR_W+1 = WIDTH+1.

Parameters:
- ADDR_W, 9, RAM address width; FIFO depth = 2**ADDR_W (512); must equal the package WIDTH.
- AF_THRESH, 480, fill level at or above which almost_full asserts; legal range 1..2**ADDR_W.

Ports:
- clk  in  1  write-domain clock; all state on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request from the producer
- rd_gray_async  in  ADDR_W+1  read-side Gray pointer, asynchronous to clk
- mem_we  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address (binary pointer LSBs)
- wr_gray  out  ADDR_W+1  registered Gray write pointer, sent to the read domain
- full  out  1  FIFO full; writes are ignored while high
- almost_full  out  1  wr_level >= AF_THRESH
- wr_level  out  ADDR_W+1  entries in the FIFO as seen by the write side, 0..2**ADDR_W
- overflow  out  1  sticky; a write was attempted while full

Behaviour:
- Reset (rst high at a clk edge): all of the following clear to 0 at that edge:
  - wr_bin, wr_gray, rd_sync1, rd_sync2, full, almost_full, wr_level, overflow.
  - rst takes priority over every other event, including a write in the same cycle.
  - Reset mid-operation discards all contents; the read side must be reset coherently (system-level requirement).
- Synchroniser: rd_sync1 <= rd_gray_async; rd_sync2 <= rd_sync1. Only rd_sync2 is used by downstream logic.
- Accept rule: mem_we = wr_en & ~full & ~rst (combinational). wr_addr = wr_bin[ADDR_W-1:0] (combinational from the register).
- On accept:
  - wr_bin_nxt = wr_bin + 1, modulo 2**(ADDR_W+1). Wraps 1023 -> 0 for the default.
  - wr_gray <= bin2gray(wr_bin_nxt).
  - Otherwise wr_bin_nxt = wr_bin.
- Full (registered):
  - full <= (bin2gray(wr_bin_nxt) == {~rd_sync2[ADDR_W:ADDR_W-1], rd_sync2[ADDR_W-2:0]}).
  - Assertion is same-edge: full rises at the edge that accepts the filling write. A write in the following cycle is never accepted.
  - Deassertion is pessimistic: it follows a read-pointer change by 3 clk edges (2 synchroniser edges + 1 register edge).
- Level (registered): wr_level <= (wr_bin_nxt - gray2bin(rd_sync2)) mod 2**(ADDR_W+1). Range is 0..512, and full implies wr_level = 512.
- almost_full (registered): almost_full <= (level_nxt >= AF_THRESH), updated on the same edge as wr_level.
- Overflow: overflow <= overflow | (wr_en & full). Cleared only by rst. An attempted write while full changes no pointer.
- Simultaneous events:
  - A write and a read-pointer change in the same cycle are both reflected.
  - The read change becomes visible 2 edges later; the write becomes visible immediately.
- Gray invariant: wr_gray changes by exactly one bit per accepted write and never changes without an accept.

Test Plan:
- Reset/idle: rst high 2 cycles, rd_gray_async=0 -> all outputs 0; wr_en low 10 cycles -> wr_gray stays 0x000.
- Fill to full: rd_gray_async=0, wr_en=1 for 513 cycles -> 512 mem_we pulses (wr_addr 0..511); full=1 at the 512th accepting edge with wr_gray=0x300 and wr_level=512; 513th request -> mem_we=0, overflow=1.
- Almost-full: 480 writes from empty -> almost_full rises on the 480th write's edge; wr_level=480, full=0.
- Read release: from full, set rd_gray_async=0x001 -> full stays 1 for 2 edges and falls on the 3rd; wr_level=511, overflow stays 1.
- Wrap-around: advance reads and writes in step for 1100 writes -> wr_bin wraps 1023->0; wr_gray steps 0x200->0x000; exactly one bit changes per write (checked by assertion); no false full.
- Reset mid-fill: 300 writes, then rst for 1 cycle with wr_en=1 -> mem_we=0 during rst; the next edge holds wr_gray=0, wr_level=0, overflow=0.
